ram_clk_reset_seq: RTL



---
 rtl/ram_clk_reset_pkg.sv | 19 +
 rtl/sync_bit.sv | 20 ++
 rtl/ram_clk_reset_seq.sv | 107 ++++++++++
 3 files changed

// File: rtl/ram_clk_reset_pkg.sv
// Shared types and default constants for the RAM-clock reset sequencer.
package ram_clk_reset_pkg;

   typedef enum logic [2:0] {
      WAIT_LOCK = 3'd0,
      STABLE    = 3'd1,
      RELEASE   = 3'd2,
      RUN       = 3'd3,
      HOLD      = 3'd4
   } state_t;

   localparam int DEF_SYNC_STAGES        = 2;
   localparam int DEF_LOCK_STABLE_CYCLES = 1024;
   localparam int DEF_NUM_DOMAINS        = 3;
   localparam int DEF_STAGE_GAP          = 16;
   localparam int DEF_HOLD_CYCLES        = 64;
   localparam int DEF_LOSS_CNT_W         = 8;

endpackage

// File: rtl/sync_bit.sv
// N-flop single-bit synchronizer with async active-low reset; output is the last flop.
module sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ff <= '0;
      else        ff <= {ff[STAGES-2:0], d};
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/ram_clk_reset_seq.sv
// Qualifies PLL lock, then releases staged domain resets; re-asserts on lock loss or sw request.
module ram_clk_reset_seq
   import ram_clk_reset_pkg::*;
#(
   parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
   parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
   parameter int NUM_DOMAINS        = DEF_NUM_DOMAINS,
   parameter int STAGE_GAP          = DEF_STAGE_GAP,
   parameter int HOLD_CYCLES        = DEF_HOLD_CYCLES,
   parameter int LOSS_CNT_W         = DEF_LOSS_CNT_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   pll_lock,
   input  logic                   sw_reset_req,
   output logic [NUM_DOMAINS-1:0] rst_out_n,
   output logic                   ready,
   output logic [LOSS_CNT_W-1:0]  lock_loss_cnt,
   output logic [2:0]             state_o
);

   localparam int SW = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
   localparam int GW = (STAGE_GAP > 1)          ? $clog2(STAGE_GAP)          : 1;
   localparam int HW = (HOLD_CYCLES > 1)        ? $clog2(HOLD_CYCLES)        : 1;

   localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LAST    = GW'(STAGE_GAP - 1);
   localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);

   state_t                 state;
   logic                   lock_s;
   logic [SW-1:0]          stable_cnt;
   logic [GW-1:0]          gap_cnt;
   logic [HW-1:0]          hold_cnt;
   logic [NUM_DOMAINS-1:0] rel_next;

   sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pll_lock),
      .q     (lock_s)
   );

   // rst_out_n is a thermometer code, so the next release just shifts in another 1
   assign rel_next = (rst_out_n << 1) | NUM_DOMAINS'(1);
   assign state_o  = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= WAIT_LOCK;
         rst_out_n     <= '0;
         ready         <= 1'b0;
         lock_loss_cnt <= '0;
         stable_cnt    <= '0;
         gap_cnt       <= '0;
         hold_cnt      <= '0;
      end else begin
         case (state)
            WAIT_LOCK: begin
               rst_out_n  <= '0;
               ready      <= 1'b0;
               stable_cnt <= '0;
               if (lock_s && !sw_reset_req) state <= STABLE;
            end
            STABLE: begin
               if (!lock_s || sw_reset_req) begin
                  state      <= WAIT_LOCK;
                  stable_cnt <= '0;
               end else if (stable_cnt == STABLE_LAST) begin
                  rst_out_n <= NUM_DOMAINS'(1);
                  gap_cnt   <= '0;
                  state     <= (NUM_DOMAINS == 1) ? RUN : RELEASE;
               end else begin
                  stable_cnt <= stable_cnt + 1'b1;
               end
            end
            RELEASE, RUN: begin
               if (!lock_s || sw_reset_req) begin
                  // lock loss wins over a coincident request; either way count at most once
                  rst_out_n <= '0;
                  ready     <= 1'b0;
                  hold_cnt  <= '0;
                  state     <= HOLD;
                  if (!lock_s && lock_loss_cnt != '1)
                     lock_loss_cnt <= lock_loss_cnt + 1'b1;
               end else if (state == RELEASE) begin
                  if (gap_cnt == GAP_LAST) begin
                     gap_cnt   <= '0;
                     rst_out_n <= rel_next;
                     if (&rel_next) state <= RUN;
                  end else begin
                     gap_cnt <= gap_cnt + 1'b1;
                  end
               end else begin
                  ready <= 1'b1;
               end
            end
            HOLD: begin
               if (hold_cnt == HOLD_LAST) state <= WAIT_LOCK;
               else                       hold_cnt <= hold_cnt + 1'b1;
            end
            default: state <= WAIT_LOCK;
         endcase
      end
   end

endmodule
